fetch_sequencer: RTL and testbench

Controller that sequences 16-byte line fetches from the instruction cache into the instruction queue. Sits between the I-cache request/response ports and the queue's write/control ports: it issues aligned line addresses, buffers returned lines in a small in-order skid FIFO, and pushes them into the queue. It also services redirects by flushing the queue and loading the byte offset, and squashes stale in-flight responses. Sized so the queue's write side never drops data.

---
 rtl/fetch_sequencer.sv | 147 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: issues aligned 16-byte I-cache line requests, buffers returned lines in an
// in-order skid FIFO and writes them to the instruction queue. FETCH_SEQ_PERF_EN adds perf counters.
module fetch_sequencer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    SKID_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hFFFF_FFF0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic                  ic_req_valid,
  input  logic                  ic_req_ready,
  output logic [ADDR_WIDTH-1:0] ic_req_addr,
  input  logic                  ic_rsp_valid,
  input  logic [127:0]          ic_rsp_data,
  output logic                  iq_valid_i,
  input  logic                  iq_ready_i,
  output logic [127:0]          iq_data_i,
  output logic                  iq_flush,
  output logic                  iq_load,
  output logic [5:0]            iq_load_address,
  output logic [15:0]           perf_stale_drops,
  output logic [15:0]           perf_stall_cycles
);
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(SKID_DEPTH);

  typedef enum logic [1:0] {INIT, RUN, HALT, REDIRECT} state_e;

  state_e                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]          fetch_addr_q, fetch_addr_d;
  logic [CW-1:0]                  outst_q, outst_d, stale_q, stale_d, cnt_q, cnt_d;
  logic [PW-1:0]                  rd_q, rd_d, wr_q, wr_d;
  logic [3:0]                     load_off_q, load_off_d;
  logic [SKID_DEPTH-1:0][127:0]   mem_q;
  logic credit, redir, accept, drop, push, pop, in_redir;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits cover both in-flight requests and buffered lines, so the FIFO can never overflow.
  assign credit   = ({1'b0, outst_q} + {1'b0, cnt_q}) < DEPTH_C;
  assign in_redir = (state_q == REDIRECT);
  assign redir    = redirect_valid & (state_q != INIT);
  assign accept   = ic_req_valid & ic_req_ready;
  assign drop     = ic_rsp_valid & (stale_q != '0);
  assign push     = ic_rsp_valid & (stale_q == '0);
  assign pop      = iq_valid_i & iq_ready_i;

  assign ic_req_valid    = (state_q == RUN) & ~halt & ~redirect_valid & credit;
  assign ic_req_addr     = fetch_addr_q;
  assign iq_valid_i      = (cnt_q != '0) & ~in_redir;
  assign iq_data_i       = mem_q[rd_q];
  // Pulses are decoded from state; masked while reset is held so reset outputs read 0.
  assign iq_flush        = ~reset & ((state_q == INIT) | in_redir);
  assign iq_load         = iq_flush;
  assign iq_load_address = {2'b00, load_off_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:     state_d = halt ? HALT : RUN;
      RUN:      if (halt) state_d = HALT;
      HALT:     if (!halt) state_d = RUN;
      REDIRECT: state_d = halt ? HALT : RUN;
      default:  state_d = INIT;
    endcase
    if (redir) state_d = REDIRECT;

    fetch_addr_d = fetch_addr_q;
    if (accept) fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(16);
    if (redir)  fetch_addr_d = {redirect_pc[ADDR_WIDTH-1:4], 4'b0000};

    outst_d = outst_q + CW'(accept) - CW'(ic_rsp_valid);

    // Everything still in flight when the redirect lands belongs to the old stream.
    stale_d = drop ? stale_q - 1'b1 : stale_q;
    if (redir) stale_d = outst_d;

    cnt_d = cnt_q + CW'(push) - CW'(pop);
    wr_d  = push ? ptr_inc(wr_q) : wr_q;
    rd_d  = pop ? ptr_inc(rd_q) : rd_q;
    if (redir) begin
      cnt_d = '0;
      wr_d  = '0;
      rd_d  = '0;
    end

    load_off_d = redir ? redirect_pc[3:0] : load_off_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= INIT;
      fetch_addr_q <= {RESET_PC[ADDR_WIDTH-1:4], 4'b0000};
      outst_q      <= '0;
      stale_q      <= '0;
      cnt_q        <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      load_off_q   <= RESET_PC[3:0];
      mem_q        <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      outst_q      <= outst_d;
      stale_q      <= stale_d;
      cnt_q        <= cnt_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      load_off_q   <= load_off_d;
      if (push) mem_q[wr_q] <= ic_rsp_data;
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] drops_q, drops_d, stall_q, stall_d;

  always_comb begin
    drops_d = drops_q;
    stall_d = stall_q;
    if (drop && drops_q != 16'hFFFF) drops_d = drops_q + 16'd1;
    if (state_q == RUN && !credit && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drops_q <= '0;
      stall_q <= '0;
    end else begin
      drops_q <= drops_d;
      stall_q <= stall_d;
    end
  end

  assign perf_stale_drops  = drops_q;
  assign perf_stall_cycles = stall_q;
`else
  assign perf_stale_drops  = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run checked against a
// line-stream model (requests and queue writes must follow the current fetch target in 16B steps).
module tb_fetch_sequencer;
  localparam int SD = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = '0;
  logic         halt = 1'b0;
  logic         ic_req_valid;
  logic         ic_req_ready = 1'b0;
  logic [31:0]  ic_req_addr;
  logic         ic_rsp_valid = 1'b0;
  logic [127:0] ic_rsp_data = '0;
  logic         iq_valid_i;
  logic         iq_ready_i = 1'b0;
  logic [127:0] iq_data_i;
  logic         iq_flush, iq_load;
  logic [5:0]   iq_load_address;
  logic [15:0]  perf_stale_drops, perf_stall_cycles;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_WIDTH(32), .SKID_DEPTH(SD), .RESET_PC(32'h0000_1008)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready),
    .ic_req_addr(ic_req_addr), .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
    .iq_valid_i(iq_valid_i), .iq_ready_i(iq_ready_i), .iq_data_i(iq_data_i),
    .iq_flush(iq_flush), .iq_load(iq_load), .iq_load_address(iq_load_address),
    .perf_stale_drops(perf_stale_drops), .perf_stall_cycles(perf_stall_cycles)
  );

  // I-cache model: accepted requests wait here, tagged with the fetch epoch they were issued in.
  logic [31:0]  pend[$];
  int           pend_ep[$];
  int           cur_ep = 0;
  logic [127:0] wr_log[$];
  logic [31:0]  req_log[$];

  logic         o_req_v, o_req_acc, o_iqv, o_wr, o_flush, o_load, o_rsp;
  logic [31:0]  o_req_addr;
  logic [127:0] o_data;
  logic [5:0]   o_laddr;
  int           o_rsp_ep = 0;

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1234_5678};
  endfunction

  // One clock: drive at posedge+1, observe at negedge, return just after the next posedge.
  task automatic cyc(input bit rv, input logic [31:0] rpc, input bit hlt, input bit rrdy,
                     input bit rsp, input bit qrdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = hlt;
    ic_req_ready   = rrdy;
    iq_ready_i     = qrdy;
    o_rsp          = rsp && (pend.size() > 0);
    ic_rsp_valid   = o_rsp;
    ic_rsp_data    = o_rsp ? line_of(pend[0]) : '0;
    @(negedge clk);
    o_req_v    = ic_req_valid;
    o_req_addr = ic_req_addr;
    o_req_acc  = ic_req_valid & rrdy;
    o_iqv      = iq_valid_i;
    o_wr       = iq_valid_i & qrdy;
    o_data     = iq_data_i;
    o_flush    = iq_flush;
    o_load     = iq_load;
    o_laddr    = iq_load_address;
    if (o_rsp) begin
      o_rsp_ep = pend_ep[0];
      pend.delete(0);
      pend_ep.delete(0);
    end
    if (o_req_acc === 1'b1) begin
      pend.push_back(ic_req_addr);
      pend_ep.push_back(cur_ep);
      req_log.push_back(ic_req_addr);
    end
    if (o_wr === 1'b1) wr_log.push_back(iq_data_i);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; halt = 1'b0; ic_req_ready = 1'b0;
    ic_rsp_valid = 1'b0; iq_ready_i = 1'b0; ic_rsp_data = '0;
    pend.delete(); pend_ep.delete(); wr_log.delete(); req_log.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; halt = 1'b0; ic_req_ready = 1'b0;
    ic_rsp_valid = 1'b0; iq_ready_i = 1'b0;
    pend.delete(); pend_ep.delete(); wr_log.delete(); req_log.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({iq_flush, iq_load, ic_req_valid, iq_valid_i} !== 4'b0000) begin
      n_err++; $display("FAIL reset_outputs got %b exp 0000", {iq_flush, iq_load, ic_req_valid, iq_valid_i});
    end
    n_chk++;
    if (iq_load_address !== 6'h08) begin
      n_err++; $display("FAIL reset_load_addr got %h exp 08", iq_load_address);
    end
    n_chk++;
    if (iq_data_i !== '0 || perf_stale_drops !== 16'h0 || perf_stall_cycles !== 16'h0) begin
      n_err++; $display("FAIL reset_data_perf got %h %h %h exp 0", iq_data_i, perf_stale_drops, perf_stall_cycles);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(0, 0, 0, 1, 0, 0);
    n_chk++;
    if (o_flush !== 1'b1 || o_load !== 1'b1 || o_laddr !== 6'h08 || o_req_v !== 1'b0) begin
      n_err++; $display("FAIL init_pulse got flush=%b load=%b addr=%h req=%b exp 1 1 08 0", o_flush, o_load, o_laddr, o_req_v);
    end
    cyc(0, 0, 0, 1, 0, 0);
    n_chk++;
    if (o_req_acc !== 1'b1 || o_req_addr !== 32'h1000) begin
      n_err++; $display("FAIL first_req got acc=%b addr=%h exp 1 00001000", o_req_acc, o_req_addr);
    end
    cyc(0, 0, 0, 1, 0, 0);
    n_chk++;
    if (o_req_acc !== 1'b1 || o_req_addr !== 32'h1010 || o_flush !== 1'b0) begin
      n_err++; $display("FAIL second_req got acc=%b addr=%h flush=%b exp 1 00001010 0", o_req_acc, o_req_addr, o_flush);
    end
    cyc(0, 0, 0, 1, 0, 0);
    n_chk++;
    if (o_req_v !== 1'b0) begin
      n_err++; $display("FAIL credit_block got %b exp 0", o_req_v);
    end
    repeat (6) cyc(0, 0, 0, 0, 1, 1);
    n_chk++;
    if (wr_log.size() != 2 || wr_log[0] !== line_of(32'h1000) || wr_log[1] !== line_of(32'h1010)) begin
      n_err++; $display("FAIL reset_stream got %0d writes exp 2 lines 1000,1010", wr_log.size());
    end
  endtask

  task automatic test_backpressure();
    int acc;
    do_reset();
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 1, 1, 0);
      if (o_req_acc === 1'b1) acc++;
    end
    n_chk++;
    if (acc != 2) begin
      n_err++; $display("FAIL bp_accepts got %0d exp 2", acc);
    end
    n_chk++;
    if (o_req_v !== 1'b0 || o_iqv !== 1'b1) begin
      n_err++; $display("FAIL bp_full got req=%b iqv=%b exp 0 1", o_req_v, o_iqv);
    end
    repeat (4) cyc(0, 0, 0, 0, 1, 1);
    n_chk++;
    if (wr_log.size() != 2 || wr_log[0] !== line_of(32'h1000) || wr_log[1] !== line_of(32'h1010)) begin
      n_err++; $display("FAIL bp_no_loss got %0d writes exp 2 lines 1000,1010", wr_log.size());
    end
  endtask

  task automatic test_redirect();
    do_reset();
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 32'h2004, 0, 1, 0, 1);
    n_chk++;
    if (o_req_v !== 1'b0) begin
      n_err++; $display("FAIL redir_req_drop got %b exp 0", o_req_v);
    end
    wr_log.delete(); req_log.delete();
    cyc(0, 0, 0, 1, 1, 1);
    n_chk++;
    if (o_flush !== 1'b1 || o_load !== 1'b1 || o_laddr !== 6'h04 || o_iqv !== 1'b0 || o_req_v !== 1'b0) begin
      n_err++; $display("FAIL redir_pulse got %b%b addr=%h iqv=%b req=%b exp 11 04 0 0", o_flush, o_load, o_laddr, o_iqv, o_req_v);
    end
    repeat (8) cyc(0, 0, 0, 1, 1, 1);
    repeat (6) cyc(0, 0, 0, 0, 1, 1);
    n_chk++;
    if (req_log.size() < 1 || req_log[0] !== 32'h2000) begin
      n_err++; $display("FAIL redir_first_req got %0d reqs exp first 00002000", req_log.size());
    end
    n_chk++;
    if (wr_log.size() < 2 || wr_log[0] !== line_of(32'h2000) || wr_log[1] !== line_of(32'h2010)) begin
      n_err++; $display("FAIL redir_stream got %0d writes exp lines 2000,2010 first", wr_log.size());
    end
`ifdef FETCH_SEQ_PERF_EN
    n_chk++;
    if (perf_stale_drops !== 16'd2) begin
      n_err++; $display("FAIL perf_drops got %0d exp 2", perf_stale_drops);
    end
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    cyc(1, 32'hFFFF_FFF0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    n_chk++;
    if (o_req_v !== 1'b0 || o_laddr !== 6'h00) begin
      n_err++; $display("FAIL wrap_redir got req=%b addr=%h exp 0 00", o_req_v, o_laddr);
    end
    cyc(0, 0, 0, 1, 0, 0);
    n_chk++;
    if (o_req_acc !== 1'b1 || o_req_addr !== 32'hFFFF_FFF0) begin
      n_err++; $display("FAIL wrap_top got acc=%b addr=%h exp 1 fffffff0", o_req_acc, o_req_addr);
    end
    cyc(0, 0, 0, 1, 0, 0);
    n_chk++;
    if (o_req_acc !== 1'b1 || o_req_addr !== 32'h0) begin
      n_err++; $display("FAIL wrap_zero got acc=%b addr=%h exp 1 00000000", o_req_acc, o_req_addr);
    end
  endtask

  task automatic test_halt();
    bit any_req;
    bit got;
    do_reset();
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 1);
    n_chk++;
    if (o_req_v !== 1'b0) begin
      n_err++; $display("FAIL halt_comb got %b exp 0", o_req_v);
    end
    any_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 1, 1, 1);
      if (o_req_v !== 1'b0) any_req = 1'b1;
    end
    n_chk++;
    if (any_req) begin
      n_err++; $display("FAIL halt_no_req got 1 exp 0");
    end
    n_chk++;
    if (wr_log.size() != 1 || wr_log[0] !== line_of(32'h1000)) begin
      n_err++; $display("FAIL halt_write got %0d writes exp 1 line 1000", wr_log.size());
    end
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      cyc(0, 0, 0, 1, 0, 1);
      if (o_req_acc === 1'b1) got = 1'b1;
    end
    n_chk++;
    if (!got || o_req_addr !== 32'h1010) begin
      n_err++; $display("FAIL halt_resume got acc=%b addr=%h exp 1 00001010", got, o_req_addr);
    end
  endtask

  task automatic test_collision();
    do_reset();
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(1, 32'h3008, 0, 1, 1, 1);
    wr_log.delete();
    cyc(0, 0, 0, 1, 0, 1);
    n_chk++;
    if (o_flush !== 1'b1 || o_laddr !== 6'h08 || o_iqv !== 1'b0) begin
      n_err++; $display("FAIL coll_pulse got flush=%b addr=%h iqv=%b exp 1 08 0", o_flush, o_laddr, o_iqv);
    end
    cyc(0, 0, 0, 1, 0, 1);
    n_chk++;
    if (o_iqv !== 1'b0 || o_req_acc !== 1'b1 || o_req_addr !== 32'h3000) begin
      n_err++; $display("FAIL coll_after got iqv=%b acc=%b addr=%h exp 0 1 00003000", o_iqv, o_req_acc, o_req_addr);
    end
    repeat (5) cyc(0, 0, 0, 0, 1, 1);
    n_chk++;
    if (wr_log.size() != 1 || wr_log[0] !== line_of(32'h3000)) begin
      n_err++; $display("FAIL coll_stream got %0d writes exp 1 line 3000", wr_log.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_req, exp_wr, rpc;
    int buffered;
    bit hlt, rv, drain, h_in;
    do_reset();
    exp_req = 32'h1000; exp_wr = 32'h1000; buffered = 0; hlt = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      drain = (c >= 1480);
      if ($urandom_range(0, 19) == 0) hlt = ~hlt;
      h_in = drain ? 1'b0 : hlt;
      rv   = !drain && ($urandom_range(0, 24) == 0);
      rpc  = $urandom;
      cyc(rv, rpc, h_in, drain ? 1'b0 : ($urandom_range(0, 9) < 7),
          drain ? 1'b1 : ($urandom_range(0, 9) < 6), drain ? 1'b1 : ($urandom_range(0, 9) < 6));
      if (h_in || rv) begin
        n_chk++;
        if (o_req_v !== 1'b0) begin
          n_err++; $display("FAIL rnd_blocked cyc %0d got req=%b exp 0", c, o_req_v);
        end
      end
      if (o_req_acc === 1'b1) begin
        n_chk++;
        if (o_req_addr !== exp_req) begin
          n_err++; $display("FAIL rnd_req cyc %0d got %h exp %h", c, o_req_addr, exp_req);
        end
        exp_req = exp_req + 32'd16;
      end
      if (o_wr === 1'b1) begin
        n_chk++;
        if (o_data !== line_of(exp_wr)) begin
          n_err++; $display("FAIL rnd_write cyc %0d got %h exp %h", c, o_data, line_of(exp_wr));
        end
        exp_wr = exp_wr + 32'd16;
        buffered--;
      end
      if (o_rsp && o_rsp_ep == cur_ep) buffered++;
      if (rv) begin
        cur_ep++;
        exp_req  = {rpc[31:4], 4'b0000};
        exp_wr   = {rpc[31:4], 4'b0000};
        buffered = 0;
      end
      n_chk++;
      if (pend.size() + buffered > SD) begin
        n_err++; $display("FAIL rnd_credit cyc %0d got %0d exp <= %0d", c, pend.size() + buffered, SD);
      end
    end
    n_chk++;
    if (o_iqv !== 1'b0 || buffered != 0 || pend.size() != 0) begin
      n_err++; $display("FAIL rnd_drain got iqv=%b buf=%0d pend=%0d exp 0 0 0", o_iqv, buffered, pend.size());
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
